// File: rtl/div_iter_unit_if.sv
// rtl/div_iter_unit_if.sv - request/response channel between EX and the iterative divider
interface div_iter_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [XLEN-1:0]  req_op1;
  logic [XLEN-1:0]  req_op2;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_funct3, req_op1, req_op2, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_funct3, req_op1, req_op2, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module div_iter_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  div_iter_unit_if.slave dv,
  output logic           busy
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [XLEN-1:0]  dq;
  logic [XLEN-1:0]  divisor;
  logic [XLEN-1:0]  rem;
  logic [CW-1:0]    cnt;
  logic             sel_rem;
  logic             neg_q;
  logic             neg_r;
  logic [TAG_W-1:0] tag_q;

  logic             accept;
  logic             signed_op;
  logic             div_zero;
  logic             overflow;
  logic [XLEN-1:0]  op1_abs;
  logic [XLEN-1:0]  op2_abs;
  logic [XLEN-1:0]  fast_res;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;
  logic             ge;
  logic [XLEN-1:0]  rem_next;
  logic [XLEN-1:0]  dq_next;
  logic [XLEN-1:0]  res_mag;
  logic [XLEN-1:0]  res_fin;

  assign dv.req_ready = (state == IDLE) && !flush && !reset;
  assign busy         = (state != IDLE);
  assign accept       = dv.req_valid && dv.req_ready;

  assign signed_op = !dv.req_funct3[0];
  assign op1_abs   = (signed_op && dv.req_op1[XLEN-1]) ? -dv.req_op1 : dv.req_op1;
  assign op2_abs   = (signed_op && dv.req_op2[XLEN-1]) ? -dv.req_op2 : dv.req_op2;
  assign div_zero  = (dv.req_op2 == '0);
  assign overflow  = signed_op && (dv.req_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (&dv.req_op2);

  // Fast-path results are architectural constants and bypass sign correction.
  assign fast_res = dv.req_funct3[1] ? (div_zero ? dv.req_op1 : '0)
                                     : (div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}});

  // Partial remainder is XLEN+1 bits; a clear top bit of the difference means it fit.
  assign shifted  = {rem, dq[XLEN-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign ge       = !diff[XLEN];
  assign rem_next = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign dq_next  = {dq[XLEN-2:0], ge};

  assign res_mag = sel_rem ? rem_next : dq_next;
  assign res_fin = (sel_rem ? neg_r : neg_q) ? -res_mag : res_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dq            <= '0;
      divisor       <= '0;
      rem           <= '0;
      cnt           <= '0;
      sel_rem       <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      tag_q         <= '0;
      dv.resp_valid <= 1'b0;
      dv.resp_data  <= '0;
      dv.resp_tag   <= '0;
    end else if (flush) begin
      state         <= IDLE;
      cnt           <= '0;
      dv.resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sel_rem <= dv.req_funct3[1];
            tag_q   <= dv.req_tag;
            neg_q   <= signed_op & (dv.req_op1[XLEN-1] ^ dv.req_op2[XLEN-1]);
            neg_r   <= signed_op & dv.req_op1[XLEN-1];
            divisor <= op2_abs;
            dq      <= op1_abs;
            rem     <= '0;
            cnt     <= '0;
            if (div_zero || overflow) begin
              state         <= DONE;
              dv.resp_valid <= 1'b1;
              dv.resp_data  <= fast_res;
              dv.resp_tag   <= dv.req_tag;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          dq  <= dq_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            state         <= DONE;
            dv.resp_valid <= 1'b1;
            dv.resp_data  <= res_fin;
            dv.resp_tag   <= tag_q;
          end
        end
        DONE: begin
          if (dv.resp_ready) begin
            state         <= IDLE;
            dv.resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
